// File: rtl/audio_ctrl_pkg.sv
// Shared types and constants for the audio tone arbiter and its timing helpers.
// Holds the FSM state encoding, the tone/duration widths and the prescaler width helper.
package audio_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, PLAY, GAP} state_t;

    localparam int TONE_W = 8;
    localparam int DUR_W  = 8;

    localparam logic [TONE_W-1:0] TONE_SILENT = '0;

    // Counter width able to hold 0..div-1, never narrower than one bit.
    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/audio_tone_arbiter_if.sv
// Requester-side bundle of the audio tone arbiter: level requests, per-requester
// tone/duration slices, and the grant/done/busy responses.
interface audio_tone_arbiter_if
    import audio_ctrl_pkg::*;
#(
    parameter int NREQ = 4
) ();

    logic [NREQ-1:0]        req;
    logic [NREQ*TONE_W-1:0] tone_code;
    logic [NREQ*DUR_W-1:0]  dur_ticks;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   busy;

    modport master (
        output req, tone_code, dur_ticks,
        input  grant, done, busy
    );

    modport slave (
        input  req, tone_code, dur_ticks,
        output grant, done, busy
    );

endinterface

// File: rtl/audio_tone_arbiter_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// clr restarts the count so the next tick lands exactly TICK_DIV cycles later.
module tick_prescaler
    import audio_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = presc_width(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_tone_arbiter.sv
// Shares one tone mapper + codec between NREQ requesters: settle, play, gap sequencing.
// Define AUDIO_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module audio_tone_arbiter
    import audio_ctrl_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int TICK_DIV     = 50000,
    parameter int SETTLE_TICKS = 2,
    parameter int GAP_TICKS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    audio_tone_arbiter_if.slave   bus,
    output logic [TONE_W-1:0]     tone_code_out,
    output logic                  codec_en
);

    localparam int IW = $clog2(NREQ);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [TONE_W-1:0] code_q, code_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [DUR_W-1:0]  tcnt_q, tcnt_d;
    logic [DUR_W-1:0]  tgt;
    logic              entry_q;
    logic              tick;
    logic              clr;
    logic              last_tick;
    logic              win_valid;
    logic [IW-1:0]     win_idx;
    logic [DUR_W-1:0]  win_dur;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

`ifdef AUDIO_ARB_RR_EN
    logic [IW-1:0] last_q, last_d;

    // Search begins one past the last served index and wraps around.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_valid && bus.req[(int'(last_q) + k) % NREQ]) begin
                win_valid = 1'b1;
                win_idx   = IW'((int'(last_q) + k) % NREQ);
            end
        end
        last_d = (state_q == IDLE && win_valid) ? win_idx : last_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= IW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_valid = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        win_dur = bus.dur_ticks[int'(win_idx)*DUR_W +: DUR_W];
        case (state_q)
            SETTLE:  tgt = DUR_W'(SETTLE_TICKS);
            PLAY:    tgt = dur_q;
            GAP:     tgt = DUR_W'(GAP_TICKS);
            default: tgt = DUR_W'(1);
        endcase
        last_tick = tick && (tcnt_q == tgt - DUR_W'(1));
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        code_d  = code_q;
        dur_d   = dur_q;
        tcnt_d  = tick ? tcnt_q + DUR_W'(1) : tcnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    code_d  = bus.tone_code[int'(win_idx)*TONE_W +: TONE_W];
                    dur_d   = win_dur;
                    state_d = (win_dur == '0) ? GAP : SETTLE;
                end
            end
            SETTLE: begin
                if ((bus.req & grant_q) == '0) begin
                    state_d = GAP;
                end else if (last_tick) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if ((bus.req & grant_q) == '0 || last_tick) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (last_tick) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        clr = (state_d != state_q);
        if (clr) begin
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            code_q  <= '0;
            dur_q   <= '0;
            tcnt_q  <= '0;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            code_q  <= code_d;
            dur_q   <= dur_d;
            tcnt_q  <= tcnt_d;
            entry_q <= clr;
        end
    end

    // Outputs decode straight from state so reset silences the codec at once.
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == GAP && entry_q) ? grant_q : '0;
    assign codec_en      = (state_q == SETTLE) || (state_q == PLAY);
    assign tone_code_out = (state_q == PLAY) ? code_q : TONE_SILENT;

endmodule
